// File: rtl/led_effect_gen.sv
// LED pattern generator: prescaled step tick driving bounce, rotate, bar-fill and blink
// effects across N_LEDS outputs, with runtime effect and speed selection.
module led_effect_gen #(
    parameter int unsigned N_LEDS   = 7,
    parameter int unsigned TICK_DIV = 12500000,
    parameter int unsigned DIV_W    = 27
) (
    input  logic              clk_50M,
    input  logic              rst_n,
    input  logic              switch,
    input  logic [1:0]        mode,
    input  logic [1:0]        speed,
    output logic [N_LEDS-1:0] leds,
    output logic              step
);

    localparam int unsigned PosW = $clog2(N_LEDS + 1);

    localparam logic [PosW-1:0]   PosZero = '0;
    localparam logic [PosW-1:0]   PosOne  = PosW'(1);
    localparam logic [PosW-1:0]   LastPos = PosW'(N_LEDS - 1);
    localparam logic [PosW-1:0]   FullPos = PosW'(N_LEDS);
    localparam logic [DIV_W-1:0]  DivBase = DIV_W'(TICK_DIV);
    localparam logic [DIV_W-1:0]  CntOne  = DIV_W'(1);
    localparam logic [N_LEDS-1:0] LedOne  = N_LEDS'(1);
    localparam logic [N_LEDS:0]   FillOne = (N_LEDS + 1)'(1);

    localparam logic [1:0] ModeBounce = 2'd0;
    localparam logic [1:0] ModeRotate = 2'd1;
    localparam logic [1:0] ModeFill   = 2'd2;
    localparam logic [1:0] ModeBlink  = 2'd3;

    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [PosW-1:0]   pos_q, pos_d;
    logic              dir_q, dir_d;     // 0 = up, 1 = down
    logic              phase_q, phase_d;
    logic [1:0]        mode_q;
    logic              en_q;
    logic [N_LEDS-1:0] leds_q, leds_d;
    logic              step_q, step_d;

    logic [DIV_W-1:0]  period;
    logic [DIV_W-1:0]  last_cnt;
    logic              restart;
    logic              tick;

    // LED image for a given effect and state; the fill mask is built one bit wider so that
    // pos == N_LEDS yields all ones without overflowing.
    function automatic logic [N_LEDS-1:0] pattern(input logic [1:0]      m,
                                                   input logic [PosW-1:0] p,
                                                   input logic            ph);
        logic [N_LEDS:0] mask;
        mask = (FillOne << p) - FillOne;
        unique case (m)
            ModeBounce, ModeRotate: pattern = LedOne << p;
            ModeFill:               pattern = N_LEDS'(mask);
            default:                pattern = ph ? '0 : '1;
        endcase
    endfunction

    // Prescaler period and tick; >= catches a speed change that shortened the period.
    always_comb begin
        period   = DivBase >> speed;
        last_cnt = period - CntOne;
        tick     = (cnt_q >= last_cnt);
        restart  = !en_q || (mode != mode_q);
    end

    // Next-state: hold, restart on enable/mode change, or advance the effect on a tick.
    always_comb begin
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        phase_d = phase_q;
        step_d  = 1'b0;
        if (!switch || restart) begin
            cnt_d   = '0;
            pos_d   = PosZero;
            dir_d   = 1'b0;
            phase_d = 1'b0;
        end else if (tick) begin
            cnt_d  = '0;
            step_d = 1'b1;
            unique case (mode)
                ModeBounce: begin
                    if (!dir_q) begin
                        pos_d = pos_q + PosOne;
                        if (pos_d == LastPos) dir_d = 1'b1;
                    end else begin
                        pos_d = pos_q - PosOne;
                        if (pos_d == PosZero) dir_d = 1'b0;
                    end
                end
                ModeRotate: pos_d = (pos_q == LastPos) ? PosZero : pos_q + PosOne;
                ModeFill: begin
                    if (!dir_q) begin
                        pos_d = pos_q + PosOne;
                        if (pos_d == FullPos) dir_d = 1'b1;
                    end else begin
                        pos_d = pos_q - PosOne;
                        if (pos_d == PosZero) dir_d = 1'b0;
                    end
                end
                default: phase_d = ~phase_q;
            endcase
        end else begin
            cnt_d = cnt_q + CntOne;
        end
        leds_d = switch ? pattern(mode, pos_d, phase_d) : '0;
    end

    // State and registered outputs.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            phase_q <= 1'b0;
            mode_q  <= 2'd0;
            en_q    <= 1'b0;
            leds_q  <= '0;
            step_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            phase_q <= phase_d;
            mode_q  <= mode;
            en_q    <= switch;
            leds_q  <= leds_d;
            step_q  <= step_d;
        end
    end

    assign leds = leds_q;
    assign step = step_q;

endmodule

// File: tb/tb_led_effect_gen.sv
// Bench for led_effect_gen: three instances (4-LED fast, 4-LED blink/speed, 32-LED fill)
// checked through a scoreboard of expected LED images, one per step pulse.
module tb_led_effect_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sw_a, sw_b, sw_c;
    logic [1:0]  mode_a, mode_b, mode_c;
    logic [1:0]  speed_a, speed_b, speed_c;
    logic [3:0]  leds_a, leds_b;
    logic [31:0] leds_c;
    logic        step_a, step_b, step_c;

    int          sel;
    logic [31:0] leds_sel;
    logic        step_sel;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];

    led_effect_gen #(.N_LEDS(4), .TICK_DIV(8), .DIV_W(4)) u_dut_a (
        .clk_50M(clk), .rst_n(rst_n), .switch(sw_a), .mode(mode_a), .speed(speed_a),
        .leds(leds_a), .step(step_a)
    );

    led_effect_gen #(.N_LEDS(4), .TICK_DIV(16), .DIV_W(5)) u_dut_b (
        .clk_50M(clk), .rst_n(rst_n), .switch(sw_b), .mode(mode_b), .speed(speed_b),
        .leds(leds_b), .step(step_b)
    );

    led_effect_gen #(.N_LEDS(32), .TICK_DIV(8), .DIV_W(4)) u_dut_c (
        .clk_50M(clk), .rst_n(rst_n), .switch(sw_c), .mode(mode_c), .speed(speed_c),
        .leds(leds_c), .step(step_c)
    );

    always_comb begin
        leds_sel = '0;
        step_sel = 1'b0;
        case (sel)
            0: begin leds_sel = {28'b0, leds_a}; step_sel = step_a; end
            1: begin leds_sel = {28'b0, leds_b}; step_sel = step_b; end
            default: begin leds_sel = leds_c; step_sel = step_c; end
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Count falling edges until the selected step is seen, bounded by max.
    task automatic wait_step(input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!step_sel && n < max);
        if (!step_sel) n = -1;
    endtask

    // Drain the scoreboard: each entry must arrive exactly interval clocks after the last.
    task automatic run_sb(input string tag, input int interval);
        int          n;
        logic [31:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_step(interval + 4, n);
            check_val({tag, " interval"}, n, interval);
            check_val({tag, " leds"}, leds_sel, e);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [63:0] v;
        rst_n = 1'b0;
        sw_a = 1'b0; sw_b = 1'b0; sw_c = 1'b0;
        mode_a = 2'd0; mode_b = 2'd0; mode_c = 2'd0;
        speed_a = 2'd0; speed_b = 2'd0; speed_c = 2'd0;
        sel = 0;

        #1;
        check_val("reset leds", leds_sel, 32'h0);
        check_val("reset step", {31'b0, step_sel}, 32'h0);
        check_val("reset leds32", leds_c, 32'h0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sw_a  = 1'b1;
        @(negedge clk);
        check_val("start bounce leds", leds_sel, 32'h1);
        check_val("start bounce step", {31'b0, step_sel}, 32'h0);

        exp_q.push_back(2); exp_q.push_back(4); exp_q.push_back(8); exp_q.push_back(4);
        exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(2);
        run_sb("bounce", 8);
        exp_q.push_back(4); exp_q.push_back(8);
        run_sb("bounce top", 8);

        // Drop switch for one cycle at leds=8 going down.
        sw_a = 1'b0;
        @(negedge clk);
        check_val("disabled leds", leds_sel, 32'h0);
        check_val("disabled step", {31'b0, step_sel}, 32'h0);
        sw_a = 1'b1;
        @(negedge clk);
        check_val("reenable leds", leds_sel, 32'h1);
        exp_q.push_back(2);
        run_sb("reenable", 8);
        exp_q.push_back(4);
        run_sb("bounce pre-mode", 8);

        // Mode change bounce -> fill while leds=4.
        mode_a = 2'd2;
        @(negedge clk);
        check_val("mode chg leds", leds_sel, 32'h0);
        check_val("mode chg step", {31'b0, step_sel}, 32'h0);
        exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(7); exp_q.push_back(15);
        exp_q.push_back(7); exp_q.push_back(3); exp_q.push_back(1); exp_q.push_back(0);
        exp_q.push_back(1);
        run_sb("fill", 8);

        mode_a = 2'd1;
        @(negedge clk);
        check_val("rotate start", leds_sel, 32'h1);
        exp_q.push_back(2); exp_q.push_back(4); exp_q.push_back(8); exp_q.push_back(1);
        exp_q.push_back(2);
        run_sb("rotate", 8);

        // Asynchronous reset between clock edges.
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_val("async rst leds", leds_sel, 32'h0);
        check_val("async rst step", {31'b0, step_sel}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post rst start", leds_sel, 32'h1);
        exp_q.push_back(2);
        run_sb("post rst", 8);

        // Blink and speed changes on the TICK_DIV=16 instance.
        sel     = 1;
        mode_b  = 2'd3;
        speed_b = 2'd3;
        sw_b    = 1'b1;
        @(negedge clk);
        check_val("blink start", leds_sel, 32'hF);
        exp_q.push_back(0); exp_q.push_back(15); exp_q.push_back(0); exp_q.push_back(15);
        run_sb("blink x8", 2);
        speed_b = 2'd1;
        exp_q.push_back(0); exp_q.push_back(15);
        run_sb("blink x2", 8);
        repeat (5) @(negedge clk);
        speed_b = 2'd0;
        exp_q.push_back(0);
        run_sb("speed slower", 11);
        repeat (5) @(negedge clk);
        speed_b = 2'd3;
        exp_q.push_back(15);
        run_sb("speed faster", 1);
        exp_q.push_back(0);
        run_sb("blink resume", 2);

        // 32-LED fill: full mask must not overflow.
        sel    = 2;
        mode_c = 2'd2;
        sw_c   = 1'b1;
        @(negedge clk);
        check_val("fill32 start", leds_sel, 32'h0);
        for (int k = 1; k <= 32; k++) begin
            v = (64'd1 << k) - 64'd1;
            exp_q.push_back(v[31:0]);
        end
        exp_q.push_back(32'h7FFF_FFFF);
        exp_q.push_back(32'h3FFF_FFFF);
        run_sb("fill32", 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
